// File: rtl/msrv32_load_align_unit_if.sv
// Load request, data-memory read port and writeback response of the load align unit.
interface msrv32_load_align_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid_in;
   logic              req_ready_out;
   logic [ADDR_W-1:0] req_addr_in;
   logic [1:0]        req_size_in;
   logic              req_unsigned_in;
   logic [4:0]        req_rd_in;
   logic              dm_req_valid_out;
   logic              dm_req_ready_in;
   logic [ADDR_W-1:0] dm_addr_out;
   logic              dm_rdata_valid_in;
   logic [DATA_W-1:0] dm_rdata_in;
   logic              resp_valid_out;
   logic              resp_ready_in;
   logic [DATA_W-1:0] resp_data_out;
   logic [4:0]        resp_rd_out;
   logic              resp_misaligned_exc_out;

   modport slave (
      input  req_valid_in, req_addr_in, req_size_in, req_unsigned_in, req_rd_in,
      input  dm_req_ready_in, dm_rdata_valid_in, dm_rdata_in, resp_ready_in,
      output req_ready_out, dm_req_valid_out, dm_addr_out,
      output resp_valid_out, resp_data_out, resp_rd_out, resp_misaligned_exc_out
   );

   modport master (
      output req_valid_in, req_addr_in, req_size_in, req_unsigned_in, req_rd_in,
      output dm_req_ready_in, dm_rdata_valid_in, dm_rdata_in, resp_ready_in,
      input  req_ready_out, dm_req_valid_out, dm_addr_out,
      input  resp_valid_out, resp_data_out, resp_rd_out, resp_misaligned_exc_out
   );
endinterface

// File: rtl/msrv32_load_align_unit.sv
// Sequential load unit: one or two aligned bus reads per load, lane extraction
// and zero/sign extension, result returned over a valid/ready response.
module msrv32_load_align_unit #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int MISALIGN_EN = 1
) (
   input logic                   ms_riscv32_mp_clk_in,
   input logic                   ms_riscv32_mp_rst_n_in,
   msrv32_load_align_unit_if.slave bus
);
   localparam int B     = DATA_W / 8;
   localparam int OFF_W = $clog2(B);

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

   state_t            state, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [4:0]        rd_q;
   logic              cross_q;
   logic              exc_q;
   logic [DATA_W-1:0] beat0_q;
   logic [DATA_W-1:0] beat1_q;
   logic [ADDR_W-1:0] aligned;
   logic [DATA_W-1:0] merged_lo;
   logic              req_cross;
   logic              accept;

   function automatic int size_bytes(input logic [1:0] sz);
      case (sz)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return (DATA_W == 64) ? 8 : 4;
      endcase
   endfunction

   function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [1:0] sz);
      return (int'(off) + size_bytes(sz)) > B;
   endfunction

   // Keep the low N bytes, fill the rest with zeros or the lane's sign bit.
   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] m,
                                                input logic [1:0] sz,
                                                input logic uns);
      logic [DATA_W-1:0] r;
      logic              sign;
      int                nbits;
      nbits = 8 * size_bytes(sz);
      case (sz)
         2'd0:    sign = m[7];
         2'd1:    sign = m[15];
         default: sign = (nbits == DATA_W) ? m[DATA_W-1] : m[31];
      endcase
      r = m;
      for (int i = 8; i < DATA_W; i++) begin
         if (i >= nbits) r[i] = sign & ~uns;
      end
      return r;
   endfunction

   assign req_cross = crosses(bus.req_addr_in[OFF_W-1:0], bus.req_size_in);
   assign accept    = (state == IDLE) && bus.req_valid_in;
   assign aligned   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign merged_lo = DATA_W'({beat1_q, beat0_q} >> {addr_q[OFF_W-1:0], 3'b000});

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) state <= IDLE;
      else                         state <= state_d;
   end

   // Request context and beats; outputs are gated by state, so no reset needed.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (accept) begin
         addr_q  <= bus.req_addr_in;
         size_q  <= bus.req_size_in;
         uns_q   <= bus.req_unsigned_in;
         rd_q    <= bus.req_rd_in;
         cross_q <= req_cross;
         exc_q   <= req_cross && (MISALIGN_EN == 0);
         beat0_q <= '0;
         beat1_q <= '0;
      end
      if (state == WAIT0 && bus.dm_rdata_valid_in) beat0_q <= bus.dm_rdata_in;
      if (state == WAIT1 && bus.dm_rdata_valid_in) beat1_q <= bus.dm_rdata_in;
   end

   always_comb begin
      state_d              = state;
      bus.req_ready_out    = 1'b0;
      bus.dm_req_valid_out = 1'b0;
      bus.dm_addr_out      = '0;
      bus.resp_valid_out   = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready_out = 1'b1;
            if (bus.req_valid_in)
               state_d = (req_cross && (MISALIGN_EN == 0)) ? RESP : REQ0;
         end
         REQ0: begin
            bus.dm_req_valid_out = 1'b1;
            bus.dm_addr_out      = aligned;
            if (bus.dm_req_ready_in) state_d = WAIT0;
         end
         WAIT0: begin
            if (bus.dm_rdata_valid_in) state_d = cross_q ? REQ1 : RESP;
         end
         REQ1: begin
            bus.dm_req_valid_out = 1'b1;
            bus.dm_addr_out      = aligned + ADDR_W'(B);
            if (bus.dm_req_ready_in) state_d = WAIT1;
         end
         WAIT1: begin
            if (bus.dm_rdata_valid_in) state_d = RESP;
         end
         RESP: begin
            bus.resp_valid_out = 1'b1;
            if (bus.resp_ready_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.resp_data_out           = (state == RESP) ? extend(merged_lo, size_q, uns_q) : '0;
   assign bus.resp_rd_out             = (state == RESP) ? rd_q : 5'd0;
   assign bus.resp_misaligned_exc_out = (state == RESP) && exc_q;
endmodule

// File: tb/tb_msrv32_load_align_unit.sv
// Directed bench: 32-bit units with and without misaligned support, plus a 64-bit unit.
module tb_msrv32_load_align_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          sel = 0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_uns = 1'b0;
   logic [4:0]  req_rd = '0;
   logic        resp_ready = 1'b1;
   logic        mem_ready = 1'b1;
   logic        stray = 1'b0;

   logic        rv_a = 1'b0, rv_b = 1'b0, rv_c = 1'b0;
   logic [31:0] rdat_a = '0, rdat_b = '0;
   logic [63:0] rdat_c = '0;

   logic        o_req_ready, o_dm_valid, o_resp_valid, o_exc;
   logic [31:0] o_dm_addr;
   logic [63:0] o_resp_data;
   logic [4:0]  o_rd;

   int          dm_cnt = 0;
   logic [31:0] dm_log [0:63];
   int          n_tests = 0;
   int          n_fail = 0;
   int          lat;
   int          c0;

   always #5 clk = ~clk;

   msrv32_load_align_unit_if #(.DATA_W(32), .ADDR_W(32)) ia ();
   msrv32_load_align_unit_if #(.DATA_W(32), .ADDR_W(32)) ib ();
   msrv32_load_align_unit_if #(.DATA_W(64), .ADDR_W(32)) ic ();

   msrv32_load_align_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1)) dut_a (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n), .bus(ia));
   msrv32_load_align_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(0)) dut_b (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n), .bus(ib));
   msrv32_load_align_unit #(.DATA_W(64), .ADDR_W(32), .MISALIGN_EN(1)) dut_c (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n), .bus(ic));

   assign ia.req_valid_in = req_valid && (sel == 0);
   assign ib.req_valid_in = req_valid && (sel == 1);
   assign ic.req_valid_in = req_valid && (sel == 2);
   assign ia.req_addr_in = req_addr;   assign ib.req_addr_in = req_addr;   assign ic.req_addr_in = req_addr;
   assign ia.req_size_in = req_size;   assign ib.req_size_in = req_size;   assign ic.req_size_in = req_size;
   assign ia.req_unsigned_in = req_uns; assign ib.req_unsigned_in = req_uns; assign ic.req_unsigned_in = req_uns;
   assign ia.req_rd_in = req_rd;       assign ib.req_rd_in = req_rd;       assign ic.req_rd_in = req_rd;
   assign ia.dm_req_ready_in = mem_ready; assign ib.dm_req_ready_in = mem_ready; assign ic.dm_req_ready_in = mem_ready;
   assign ia.resp_ready_in = resp_ready; assign ib.resp_ready_in = resp_ready; assign ic.resp_ready_in = resp_ready;
   assign ia.dm_rdata_valid_in = rv_a | stray;
   assign ib.dm_rdata_valid_in = rv_b;
   assign ic.dm_rdata_valid_in = rv_c;
   assign ia.dm_rdata_in = rdat_a;
   assign ib.dm_rdata_in = rdat_b;
   assign ic.dm_rdata_in = rdat_c;

   function automatic logic [31:0] mem32(input logic [31:0] a);
      case (a)
         32'h100: return 32'h8899AABB;
         32'h104: return 32'h11223344;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [63:0] mem64(input logic [31:0] a);
      return (a == 32'h200) ? 64'h8877665544332211 : 64'h0;
   endfunction

   // Zero-wait memories: data one cycle after each accepted read.
   always @(posedge clk) begin
      rv_a   <= ia.dm_req_valid_out & ia.dm_req_ready_in;
      rv_b   <= ib.dm_req_valid_out & ib.dm_req_ready_in;
      rv_c   <= ic.dm_req_valid_out & ic.dm_req_ready_in;
      rdat_a <= mem32(ia.dm_addr_out);
      rdat_b <= mem32(ib.dm_addr_out);
      rdat_c <= mem64(ic.dm_addr_out);
      if (o_dm_valid && mem_ready) begin
         dm_log[dm_cnt[5:0]] <= o_dm_addr;
         dm_cnt <= dm_cnt + 1;
      end
   end

   always_comb begin
      o_req_ready  = ia.req_ready_out;
      o_dm_valid   = ia.dm_req_valid_out;
      o_dm_addr    = ia.dm_addr_out;
      o_resp_valid = ia.resp_valid_out;
      o_resp_data  = {32'h0, ia.resp_data_out};
      o_rd         = ia.resp_rd_out;
      o_exc        = ia.resp_misaligned_exc_out;
      if (sel == 1) begin
         o_req_ready  = ib.req_ready_out;
         o_dm_valid   = ib.dm_req_valid_out;
         o_dm_addr    = ib.dm_addr_out;
         o_resp_valid = ib.resp_valid_out;
         o_resp_data  = {32'h0, ib.resp_data_out};
         o_rd         = ib.resp_rd_out;
         o_exc        = ib.resp_misaligned_exc_out;
      end else if (sel == 2) begin
         o_req_ready  = ic.req_ready_out;
         o_dm_valid   = ic.dm_req_valid_out;
         o_dm_addr    = ic.dm_addr_out;
         o_resp_valid = ic.resp_valid_out;
         o_resp_data  = ic.resp_data_out;
         o_rd         = ic.resp_rd_out;
         o_exc        = ic.resp_misaligned_exc_out;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 64'(o_req_ready), 64'd1);
      check({tag, "_dm_valid"}, 64'(o_dm_valid), 64'd0);
      check({tag, "_dm_addr"}, 64'(o_dm_addr), 64'd0);
      check({tag, "_resp_valid"}, 64'(o_resp_valid), 64'd0);
      check({tag, "_resp_data"}, o_resp_data, 64'd0);
      check({tag, "_resp_rd"}, 64'(o_rd), 64'd0);
      check({tag, "_exc"}, 64'(o_exc), 64'd0);
   endtask

   // Issue one request; lat = cycles from accept until resp_valid is seen.
   task automatic do_load(input int s, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input logic [4:0] rd, output int l);
      @(negedge clk);
      sel      = s;
      req_addr = a;
      req_size = sz;
      req_uns  = u;
      req_rd   = rd;
      check("req_ready_before", 64'(o_req_ready), 64'd1);
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      l = 1;
      while (!o_resp_valid && l < 20) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic resp_done(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_resp_cleared"}, 64'(o_resp_valid), 64'd0);
      check({tag, "_ready_again"}, 64'(o_req_ready), 64'd1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // LB signed at 0x101
      c0 = dm_cnt;
      do_load(0, 32'h101, 2'b00, 1'b0, 5'd5, lat);
      check("lb_latency", 64'(lat), 64'd3);
      check("lb_data", o_resp_data, 64'hFFFFFFAA);
      check("lb_rd", 64'(o_rd), 64'd5);
      check("lb_exc", 64'(o_exc), 64'd0);
      check("lb_dm_count", 64'(dm_cnt - c0), 64'd1);
      check("lb_dm_addr", 64'(dm_log[c0[5:0]]), 64'h100);
      resp_done("lb");

      // LHU at 0x103 crosses into 0x104
      c0 = dm_cnt;
      do_load(0, 32'h103, 2'b01, 1'b1, 5'd6, lat);
      check("lhu_x_latency", 64'(lat), 64'd5);
      check("lhu_x_data", o_resp_data, 64'h00004488);
      check("lhu_x_rd", 64'(o_rd), 64'd6);
      check("lhu_x_dm_count", 64'(dm_cnt - c0), 64'd2);
      check("lhu_x_addr0", 64'(dm_log[c0[5:0]]), 64'h100);
      check("lhu_x_addr1", 64'(dm_log[6'(c0 + 1)]), 64'h104);
      resp_done("lhu_x");

      do_load(0, 32'h102, 2'b10, 1'b0, 5'd7, lat);
      check("lw_x_latency", 64'(lat), 64'd5);
      check("lw_x_data", o_resp_data, 64'h33448899);
      check("lw_x_exc", 64'(o_exc), 64'd0);
      resp_done("lw_x");

      // No misaligned support: crossing LW raises an exception
      c0 = dm_cnt;
      do_load(1, 32'h102, 2'b10, 1'b0, 5'd8, lat);
      check("exc_latency", 64'(lat), 64'd1);
      check("exc_flag", 64'(o_exc), 64'd1);
      check("exc_data", o_resp_data, 64'd0);
      check("exc_rd", 64'(o_rd), 64'd8);
      check("exc_no_dm", 64'(dm_cnt - c0), 64'd0);
      resp_done("exc");

      do_load(1, 32'h102, 2'b01, 1'b0, 5'd9, lat);
      check("lh_nx_latency", 64'(lat), 64'd3);
      check("lh_nx_data", o_resp_data, 64'hFFFF8899);
      check("lh_nx_exc", 64'(o_exc), 64'd0);
      resp_done("lh_nx");

      // Backpressure on both memory request and response
      @(negedge clk);
      sel = 0; req_addr = 32'h104; req_size = 2'b10; req_uns = 1'b0; req_rd = 5'd11;
      mem_ready = 1'b0; resp_ready = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp_dm_valid", 64'(o_dm_valid), 64'd1);
         check("bp_dm_addr", 64'(o_dm_addr), 64'h104);
         check("bp_req_ready", 64'(o_req_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_dm_dropped", 64'(o_dm_valid), 64'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("bp_resp_valid", 64'(o_resp_valid), 64'd1);
         check("bp_resp_data", o_resp_data, 64'h11223344);
         check("bp_resp_rd", 64'(o_rd), 64'd11);
         check("bp_req_ready_resp", 64'(o_req_ready), 64'd0);
         if (i < 2) begin
            @(posedge clk);
            #1;
         end
      end
      @(negedge clk);
      resp_ready = 1'b1;
      resp_done("bp");

      // Reset in WAIT1, then stray read data
      do_load(0, 32'h103, 2'b01, 1'b1, 5'd12, lat);
      check("rst_setup_no_early_resp", 64'(lat), 64'd5);
      resp_done("rst_setup");
      @(negedge clk);
      req_addr = 32'h103; req_size = 2'b01; req_uns = 1'b1; req_rd = 5'd13; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_wait1");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      stray = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("stray");
      @(negedge clk);
      stray = 1'b0;
      do_load(0, 32'h100, 2'b00, 1'b1, 5'd14, lat);
      check("lbu_latency", 64'(lat), 64'd3);
      check("lbu_data", o_resp_data, 64'h000000BB);
      check("lbu_rd", 64'(o_rd), 64'd14);
      resp_done("lbu");

      // 64-bit data path
      do_load(2, 32'h200, 2'b11, 1'b0, 5'd20, lat);
      check("ld_latency", 64'(lat), 64'd3);
      check("ld_data", o_resp_data, 64'h8877665544332211);
      resp_done("ld");

      do_load(2, 32'h204, 2'b10, 1'b0, 5'd21, lat);
      check("lw64_latency", 64'(lat), 64'd3);
      check("lw64_data", o_resp_data, 64'hFFFFFFFF88776655);
      check("lw64_rd", 64'(o_rd), 64'd21);
      resp_done("lw64");

      c0 = dm_cnt;
      do_load(2, 32'h206, 2'b10, 1'b0, 5'd22, lat);
      check("lw64_x_latency", 64'(lat), 64'd5);
      check("lw64_x_data", o_resp_data, 64'h0000000000008877);
      check("lw64_x_addr1", 64'(dm_log[6'(c0 + 1)]), 64'h208);
      resp_done("lw64_x");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
